// File: rtl/fb_fill_writer_pkg.sv
// Shared types for the framebuffer fill writer: SDRAM word address and FSM state.
package fb_fill_writer_pkg;
    localparam int SDRAM_ADDR_W = 24;
    localparam int FILL_DIM_W   = 12;

    typedef logic [SDRAM_ADDR_W-1:0] sdram_addr_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_ACK,
        FIN
    } fill_state_t;
endpackage

// File: rtl/fb_fill_writer_rect_addr_gen.sv
// Rectangle walker: x/y counters plus an accumulated line start, so no multiplier
// is needed. Geometry is captured on load; each advance steps one word x-then-y.
module fb_fill_writer_rect_addr_gen
    import fb_fill_writer_pkg::*;
#(
    parameter int ADDR_W = SDRAM_ADDR_W,
    parameter int DIM_W  = FILL_DIM_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              advance,
    input  logic [ADDR_W-1:0] base,
    input  logic [DIM_W-1:0]  stride,
    input  logic [DIM_W-1:0]  width,
    input  logic [DIM_W-1:0]  height,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);
    logic [DIM_W-1:0]  x;
    logic [DIM_W-1:0]  y;
    logic [DIM_W-1:0]  stride_q;
    logic [DIM_W-1:0]  width_q;
    logic [DIM_W-1:0]  height_q;
    logic [ADDR_W-1:0] line_start;
    logic              x_last;

    assign x_last = (x == width_q - DIM_W'(1));
    assign last   = x_last && (y == height_q - DIM_W'(1));
    // Address arithmetic wraps modulo 2^ADDR_W by construction.
    assign addr   = line_start + ADDR_W'(x);

    always_ff @(posedge clk) begin
        if (rst) begin
            x          <= '0;
            y          <= '0;
            stride_q   <= '0;
            width_q    <= '0;
            height_q   <= '0;
            line_start <= '0;
        end else if (load) begin
            x          <= '0;
            y          <= '0;
            stride_q   <= stride;
            width_q    <= width;
            height_q   <= height;
            line_start <= base;
        end else if (advance) begin
            if (x_last) begin
                x          <= '0;
                y          <= y + DIM_W'(1);
                line_start <= line_start + ADDR_W'(stride_q);
            end else begin
                x <= x + DIM_W'(1);
            end
        end
    end
endmodule

// File: rtl/fb_fill_writer.sv
// SDRAM fill engine: writes a constant 16-bit value over a rectangle, one
// outstanding request at a time, with CSR-style start/abort/busy/done/count.
module fb_fill_writer
    import fb_fill_writer_pkg::*;
#(
    parameter int ADDR_W = SDRAM_ADDR_W,
    parameter int DIM_W  = FILL_DIM_W
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic                abort_i,
    input  logic [ADDR_W-1:0]   base_i,
    input  logic [DIM_W-1:0]    stride_i,
    input  logic [DIM_W-1:0]    width_i,
    input  logic [DIM_W-1:0]    height_i,
    input  logic [15:0]         value_i,
    input  logic [1:0]          wmask_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [2*DIM_W-1:0]  count_o,
    output logic                sdram_wr,
    output logic [ADDR_W-1:0]   sdram_addr_x16,
    output logic [15:0]         sdram_wdata,
    output logic [1:0]          sdram_wmask,
    input  logic                sdram_rdy,
    input  logic                sdram_ack
);
    fill_state_t       state, state_nxt;
    logic [15:0]       value_q;
    logic [1:0]        wmask_q;
    logic              abort_pend;
    logic              accept;
    logic              acked;
    logic              gen_last;
    logic [ADDR_W-1:0] gen_addr;

    assign accept = (state == IDLE) && start_i;
    assign acked  = (state == WAIT_ACK) && sdram_ack;

    fb_fill_writer_rect_addr_gen #(.ADDR_W(ADDR_W), .DIM_W(DIM_W)) u_gen (
        .clk     (clk_i),
        .rst     (rst_i),
        .load    (accept),
        .advance (acked),
        .base    (base_i),
        .stride  (stride_i),
        .width   (width_i),
        .height  (height_i),
        .addr    (gen_addr),
        .last    (gen_last)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    // done_o trails FIN by a cycle so it coincides with busy_o falling.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            value_q    <= '0;
            wmask_q    <= '0;
            abort_pend <= 1'b0;
            count_o    <= '0;
            done_o     <= 1'b0;
        end else begin
            done_o <= (state == FIN);
            if (accept) begin
                value_q    <= value_i;
                wmask_q    <= wmask_i;
                abort_pend <= 1'b0;
                count_o    <= '0;
            end else if (acked) begin
                count_o <= count_o + (2*DIM_W)'(1);
            end
            if (state == WAIT_ACK && abort_i) abort_pend <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:
                if (start_i)
                    state_nxt = (width_i != '0 && height_i != '0) ? REQ : FIN;
            REQ:
                if (abort_i)        state_nxt = FIN;
                else if (sdram_rdy) state_nxt = WAIT_ACK;
            // An issued request cannot be withdrawn; abort takes effect on its ack.
            WAIT_ACK:
                if (sdram_ack)
                    state_nxt = (gen_last || abort_pend || abort_i) ? FIN : REQ;
            FIN:
                state_nxt = IDLE;
            default:
                state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_o         = (state != IDLE);
        sdram_wr       = (state == WAIT_ACK);
        sdram_addr_x16 = sdram_wr ? gen_addr : '0;
        sdram_wdata    = sdram_wr ? value_q  : '0;
        sdram_wmask    = sdram_wr ? wmask_q  : '0;
    end
endmodule

// File: doc/fb_fill_writer.md
Name: fb_fill_writer

Overview:
- SDRAM write engine that fills a rectangle of 16-bit words with a constant value. Typical uses are framebuffer clears and solid fills.
- It is the writer counterpart of the video scan-out reader. It occupies a write-capable client port of the SDRAM arbiter, alongside the CPU and video ports.
- Commands come from CSR fields (base, stride, size, value, start). Status goes back to CSRs (busy, done pulse, words written).

Parameters:
- ADDR_W, 24, SDRAM word-address width (x16 units).
- DIM_W, 12, width of the width/height/stride fields.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous, active-high reset
- start_i  in  1  one-cycle command strobe
- abort_i  in  1  one-cycle abort strobe
- base_i  in  ADDR_W  word address of the top-left word
- stride_i  in  DIM_W  words between line starts
- width_i  in  DIM_W  words per line
- height_i  in  DIM_W  number of lines
- value_i  in  16  fill data
- wmask_i  in  2  byte-enable mask, passed through to the SDRAM
- busy_o  out  1  command in progress
- done_o  out  1  one-cycle pulse at completion or abort
- count_o  out  2*DIM_W  words acknowledged in the current/last command
- sdram_wr  out  1  write request
- sdram_addr_x16  out  ADDR_W  write address
- sdram_wdata  out  16  write data
- sdram_wmask  out  2  byte mask
- sdram_rdy  in  1  arbiter/controller can accept a request
- sdram_ack  in  1  one-cycle pulse: the held request was accepted

Behaviour:
- Reset values: all outputs are 0 (busy_o, done_o, count_o, sdram_wr, sdram_addr_x16, sdram_wdata, sdram_wmask).
- Command latch: when start_i is seen in IDLE, latch base, stride, width, height, value and wmask. Later changes on these inputs are ignored until the next start. start_i outside IDLE is ignored.
- States:
  - IDLE
  - REQ: sdram_wr=0, waiting for sdram_rdy.
  - WAIT_ACK: sdram_wr=1 with addr/data/mask stable.
  - FIN
- Transitions:
  - IDLE → REQ on start_i with width≠0 and height≠0. busy_o is 1 from the next cycle.
  - IDLE → FIN on start_i with width=0 or height=0. No SDRAM access is made.
  - REQ → WAIT_ACK when sdram_rdy=1. sdram_wr rises in the following cycle, so the earliest sdram_wr is 2 cycles after start_i.
  - WAIT_ACK holds until sdram_ack=1. On that cycle: count_o++, sdram_wr cleared (registered, 0 the next cycle), and the address advances.
  - After the advance, go to REQ if words remain, otherwise to FIN. Exactly one write is outstanding at a time.
  - FIN: done_o=1 for one cycle, busy_o=0 from the next cycle, → IDLE.
- Addressing:
  - x counter runs 0..width-1; line-start register begins at base.
  - Address = line_start + x.
  - On x wrap: line_start += stride, y++.
  - Finished when y reaches height-1 and x reaches width-1 on ack.
  - All address arithmetic is modulo 2^ADDR_W, so wrap past 0xFFFFFF continues at 0. No multiplier is used; the line start is accumulated.
  - stride < width is legal (lines overlap); writes still occur in x-then-y order.
- count_o:
  - Cleared on an accepted start.
  - Holds its final value after FIN until the next start.
  - Equals width*height at normal completion.
- Abort:
  - In REQ: go to FIN immediately.
  - In WAIT_ACK: an issued request cannot be withdrawn. Keep sdram_wr until ack, count that word, then go to FIN.
  - An abort in IDLE or FIN is ignored.
  - If abort and ack occur in the same cycle, the ack is counted and the block goes to FIN.
- Simultaneous start and abort in IDLE: start wins and the abort is ignored.
- sdram_ack outside WAIT_ACK is ignored: no count change, no state change.
- Reset mid-operation: next cycle the block is in IDLE with all outputs 0, including sdram_wr dropping. Because the arbiter and controller share rst_i, the dropped write needs no handling.

Decomposition:
- Shared package (video/memory package): a typedef for the ADDR_W-bit SDRAM word address and the enum fill_state_t {IDLE, REQ, WAIT_ACK, FIN}.
- One sub-module is natural: rect_addr_gen, holding the x/y counters, the line-start accumulator and the last flag. It has advance/load inputs. The FSM and handshake stay in fb_fill_writer.

Test Plan:
- Basic fill: base=0x000100, stride=640, width=3, height=2, value=0xBEEF, wmask=2'b11, ack 1 cycle after each wr, rdy=1 → writes to 0x100, 0x101, 0x102, 0x380, 0x381, 0x382, all with 0xBEEF. Then done_o pulses once and count_o=6.
- Backpressure: same command, rdy=0 for 5 cycles and ack delayed 4 cycles per request → sdram_wr never asserts while rdy was 0. Address/data stay stable while wr=1, and there is never more than one outstanding write.
- Zero size: width=0, height=5 → no sdram_wr ever. done_o pulses 2 cycles after start and count_o=0.
- Address wrap: base=0xFFFFFE, width=4, height=1 → addresses 0xFFFFFE, 0xFFFFFF, 0x000000, 0x000001.
- Abort: abort_i during the 2nd WAIT_ACK of a 10-word fill, with ack 3 cycles later → wr held until ack, then done_o pulses, count_o=2 and no further writes. A start_i issued while busy is ignored.
- Reset: rst_i asserted while sdram_wr=1 → the next cycle has sdram_wr=0, busy_o=0, count_o=0. A new start then runs normally.
